ram_port_initiator: RTL

//  Initiator side of a Dpram port: turns sized byte-addressed load/store requests into word

---
 rtl/mem_pkg.sv | 8 +
 rtl/ram_port_initiator_load_align.sv | 26 ++
 rtl/ram_port_initiator.sv | 93 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and FSM state types plus the byte-lane mask helper
package mem_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} size_t;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [31:0] off);
    return ((32'd1 << (32'd1 << size)) - 32'd1) << off;
  endfunction
endpackage

// File: rtl/ram_port_initiator_load_align.sv
// load_align: right-justifies, masks and sign/zero-extends a RAM word for a sized load
module load_align
  import mem_pkg::*;
#(
  parameter int Wordsz = 32,
  parameter int Bytesz = 8,
  parameter int Bpw    = 4
) (
  input  logic [Wordsz-1:0]        raw,
  input  logic [$clog2(Bpw)-1:0]   off,
  input  size_t                    size,
  input  logic                     sgn,
  output logic [Wordsz-1:0]        data
);
  logic [Wordsz-1:0] sh;
  int nb;
  logic msb;
  always_comb begin
    data = '0;
    sh = raw >> (Bytesz * int'(off));
    nb = Bytesz << size;
    nb = nb > Wordsz ? Wordsz : nb;
    msb = sgn & sh[$clog2(Wordsz)'(nb - 1)];
    for (int i = 0; i < Wordsz; i++) data[i] = i < nb ? sh[i] : msb;
  end
endmodule

// File: rtl/ram_port_initiator.sv
// ram_port_initiator: sized byte-addressed load/store to word RAM port with registered outputs
module ram_port_initiator
  import mem_pkg::*;
#(
  parameter int Bufsz   = 1024,
  parameter int Wordsz  = 32,
  parameter int Bytesz  = 8,
  parameter int Addrsz  = $clog2(Bufsz),
  parameter int Bpw     = Wordsz / Bytesz,
  parameter int Baddrsz = Addrsz + $clog2(Bpw)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WRITE,
  input  logic [1:0]         REQ_SIZE,
  input  logic               REQ_SIGNED,
  input  logic [Baddrsz-1:0] REQ_ADDR,
  input  logic [Wordsz-1:0]  REQ_DATA,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [Wordsz-1:0]  RSP_DATA,
  output logic               RSP_FAULT,
  output logic [Addrsz-1:0]  RAM_ADDR,
  output logic [Bpw-1:0]     RAM_W_SEL,
  output logic [Wordsz-1:0]  RAM_IN,
  input  logic [Wordsz-1:0]  RAM_OUT
);
  localparam int Ob = $clog2(Bpw);
  state_t state, state_n;
  logic wr_q, sgn_q;
  size_t sz_q;
  logic [Ob-1:0] off_q, off;
  logic [Addrsz-1:0] waddr, addr_n;
  logic accept, fault, go, ready_n, valid_n, fault_n;
  logic [Wordsz-1:0] aligned, data_n, in_n;
  logic [Bpw-1:0] wsel_n;
  assign off = REQ_ADDR[Ob-1:0];
  assign waddr = REQ_ADDR[Baddrsz-1:Ob];
  assign accept = state == IDLE && REQ_VALID;
  assign fault = int'(REQ_SIZE) > Ob || (int'(off) & ((1 << REQ_SIZE) - 1)) != 0;
  assign go = accept && !fault;
  load_align #(.Wordsz(Wordsz), .Bytesz(Bytesz), .Bpw(Bpw)) u_align (
    .raw(RAM_OUT), .off(off_q), .size(sz_q), .sgn(sgn_q), .data(aligned)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA <= '0;
      RSP_FAULT <= 1'b0;
      RAM_ADDR <= '0;
      RAM_W_SEL <= '0;
      RAM_IN <= '0;
      wr_q <= 1'b0;
      sgn_q <= 1'b0;
      sz_q <= SZ_BYTE;
      off_q <= '0;
    end else begin
      state <= state_n;
      REQ_READY <= ready_n;
      RSP_VALID <= valid_n;
      RSP_DATA <= data_n;
      RSP_FAULT <= fault_n;
      RAM_ADDR <= addr_n;
      RAM_W_SEL <= wsel_n;
      RAM_IN <= in_n;
      if (accept) begin
        wr_q <= REQ_WRITE;
        sgn_q <= REQ_SIGNED;
        sz_q <= size_t'(REQ_SIZE);
        off_q <= off;
      end
    end
  end
  always_comb
    state_n = state == IDLE    ? (accept ? (fault ? RESP : ISSUE) : IDLE) :
              state == ISSUE   ? (wr_q ? RESP : CAPTURE) :
              state == CAPTURE ? RESP :
              (RSP_READY ? IDLE : RESP);
  // next-cycle values of the registered outputs
  always_comb begin
    ready_n = state_n == IDLE;
    valid_n = state_n == RESP;
    data_n = state == CAPTURE ? aligned : state == RESP && !RSP_READY ? RSP_DATA : '0;
    fault_n = accept ? fault : state == RESP && !RSP_READY ? RSP_FAULT : 1'b0;
    addr_n = go ? waddr : RAM_ADDR;
    wsel_n = go && REQ_WRITE ? Bpw'(lane_mask(REQ_SIZE, 32'(off))) : '0;
    in_n = go && REQ_WRITE ? REQ_DATA << (Bytesz * int'(off)) : RAM_IN;
  end
endmodule
